// File: rtl/hazard_control.sv
// hazard_control: per-cycle stall/flush generation for the 5-stage MIPS
// pipeline. Covers load-use hazards, HI/LO and mul/div hazards while the
// multi-cycle multiply/divide unit is busy, and taken branches and jumps
// resolved in ID. It also keeps a saturating count of stalled cycles.
module hazard_control #(
  parameter int MULDIV_LATENCY = 4,
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_W          = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic                  ID_IsMulDiv,
  input  logic                  ID_ReadsHiLo,
  input  logic                  ID_BranchTaken,
  input  logic                  ID_Jump,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic                  EX_MulDivStart,
  output logic                  STALL_PC,
  output logic                  STALL_IFID,
  output logic                  FLUSH_IFID,
  output logic                  FLUSH_IDEX,
  output logic                  MulDivBusy,
  output logic [CNT_W-1:0]      StallCount
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // The start cycle is the first of MULDIV_LATENCY EX cycles, so the unit
  // stays busy for the remaining MULDIV_LATENCY-1 cycles after it.
  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LATENCY - 1);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic busy;
  logic lu_hazard;
  logic md_hazard;
  logic stall;
  logic ctrl_flush;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection and control priority (stall beats flush).
  always_comb begin
    busy       = (state_q == BUSY);
    // A load into $zero never produces a usable value, so it never stalls.
    lu_hazard  = IDEX_MemRead && (IDEX_Rt != '0) &&
                 ((IDEX_Rt == ID_Rs) || (ID_UsesRt && (IDEX_Rt == ID_Rt)));
    md_hazard  = busy && (ID_ReadsHiLo || ID_IsMulDiv);
    stall      = !RESET && (lu_hazard || md_hazard);
    // A stalled branch/jump is held in ID and re-resolves next cycle.
    ctrl_flush = !RESET && !stall && (ID_BranchTaken || ID_Jump);

    STALL_PC   = stall;
    STALL_IFID = stall;
    FLUSH_IDEX = stall;
    FLUSH_IFID = ctrl_flush;
    MulDivBusy = busy && !RESET;
    StallCount = RESET ? '0 : stall_cnt_q;
  end

  // Multiply/divide occupancy FSM with a 4-bit down-counter.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (EX_MulDivStart) begin
            state_q <= BUSY;
            cnt_q   <= LAT_M1;
          end
        end
        BUSY: begin
          // A start while busy only happens if stalling failed upstream;
          // treat it as a fresh operation so the timing stays consistent.
          if (EX_MulDivStart) begin
            cnt_q <= LAT_M1;
          end else if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Next value of the stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (STALL_IFID) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // Stall-cycle performance counter register.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed and randomized stimulus for hazard_control.
// Expected outputs are pushed to a scoreboard queue as each cycle is driven
// and popped on the following falling edge to be compared against both a
// default instance and an instance with a 4-bit stall counter.
module tb_hazard_control;

  localparam int LAT = 4;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [4:0] ID_Rs, ID_Rt, IDEX_Rt;
  logic       ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo, ID_BranchTaken, ID_Jump;
  logic       IDEX_MemRead, EX_MulDivStart;

  logic        pc, ifid, fifid, fidex, busy;
  logic [15:0] sc16;
  logic        s_pc, s_ifid, s_fifid, s_fidex, s_busy;
  logic [3:0]  sc4;

  typedef struct {
    logic        pc;
    logic        ifid;
    logic        fifid;
    logic        fidex;
    logic        busy;
    int          c16;
    int          c4;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_busy_left = 0;
  int m_sc16 = 0;
  int m_sc4 = 0;

  always #5 CLOCK = ~CLOCK;

  hazard_control #(.MULDIV_LATENCY(LAT), .REG_ADDR_W(5), .CNT_W(16)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRt(ID_UsesRt), .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
    .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Rt(IDEX_Rt), .EX_MulDivStart(EX_MulDivStart),
    .STALL_PC(pc), .STALL_IFID(ifid), .FLUSH_IFID(fifid), .FLUSH_IDEX(fidex),
    .MulDivBusy(busy), .StallCount(sc16)
  );

  hazard_control #(.MULDIV_LATENCY(LAT), .REG_ADDR_W(5), .CNT_W(4)) dut_sat (
    .CLOCK(CLOCK), .RESET(RESET), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRt(ID_UsesRt), .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
    .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Rt(IDEX_Rt), .EX_MulDivStart(EX_MulDivStart),
    .STALL_PC(s_pc), .STALL_IFID(s_ifid), .FLUSH_IFID(s_fifid), .FLUSH_IDEX(s_fidex),
    .MulDivBusy(s_busy), .StallCount(sc4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RESET = 1'b0; ID_Rs = '0; ID_Rt = '0; IDEX_Rt = '0;
    ID_UsesRt = 1'b0; ID_IsMulDiv = 1'b0; ID_ReadsHiLo = 1'b0;
    ID_BranchTaken = 1'b0; ID_Jump = 1'b0; IDEX_MemRead = 1'b0;
    EX_MulDivStart = 1'b0;
  endtask

  // Compute expectations for the inputs currently driven, push them,
  // compare on the falling edge, then advance the model across the
  // rising edge.
  task automatic cyc(input string tag);
    exp_t e;
    exp_t g;
    logic lu, md, st, mb;
    lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
         ((IDEX_Rt == ID_Rs) || (ID_UsesRt && (IDEX_Rt == ID_Rt)));
    mb = !RESET && (m_busy_left > 0);
    md = mb && (ID_ReadsHiLo || ID_IsMulDiv);
    st = !RESET && (lu || md);
    e.pc = st; e.ifid = st; e.fidex = st;
    e.fifid = !RESET && !st && (ID_BranchTaken || ID_Jump);
    e.busy = mb;
    e.c16 = RESET ? 0 : m_sc16;
    e.c4  = RESET ? 0 : m_sc4;
    q.push_back(e);

    @(negedge CLOCK);
    if (q.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
    end else begin
      g = q.pop_front();
      chk({tag, ".STALL_PC"},   int'(pc),    int'(g.pc));
      chk({tag, ".STALL_IFID"}, int'(ifid),  int'(g.ifid));
      chk({tag, ".FLUSH_IFID"}, int'(fifid), int'(g.fifid));
      chk({tag, ".FLUSH_IDEX"}, int'(fidex), int'(g.fidex));
      chk({tag, ".MulDivBusy"}, int'(busy),  int'(g.busy));
      chk({tag, ".StallCount"}, int'(sc16),  g.c16);
      chk({tag, ".sat.STALL_IFID"}, int'(s_ifid),  int'(g.ifid));
      chk({tag, ".sat.STALL_PC"},   int'(s_pc),    int'(g.pc));
      chk({tag, ".sat.FLUSH_IFID"}, int'(s_fifid), int'(g.fifid));
      chk({tag, ".sat.FLUSH_IDEX"}, int'(s_fidex), int'(g.fidex));
      chk({tag, ".sat.MulDivBusy"}, int'(s_busy),  int'(g.busy));
      chk({tag, ".sat.StallCount"}, int'(sc4),     g.c4);
    end

    @(posedge CLOCK);
    if (RESET) begin
      m_busy_left = 0; m_sc16 = 0; m_sc4 = 0;
    end else begin
      if (EX_MulDivStart)        m_busy_left = LAT - 1;
      else if (m_busy_left > 0)  m_busy_left = m_busy_left - 1;
      if (st && m_sc16 < 65535)  m_sc16 = m_sc16 + 1;
      if (st && m_sc4 < 15)      m_sc4 = m_sc4 + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b1;
    cyc("reset");
    RESET = 1'b0;
  endtask

  initial begin
    clear_inputs();
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;

    // Reset state
    cyc("rst0");
    cyc("rst1");
    RESET = 1'b0;

    // Load-use on rs
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; ID_Rs = 5'd8;
    cyc("lu_rs");
    clear_inputs();
    cyc("lu_rs_after");
    chk("lu_rs_count", int'(sc16), 1);

    // Load into $zero never stalls
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1;
    cyc("lu_zero");

    // rt match ignored unless the instruction reads rt
    clear_inputs();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; ID_Rs = 5'd3; ID_Rt = 5'd8; ID_UsesRt = 1'b0;
    cyc("lu_rt_unused");
    ID_UsesRt = 1'b1;
    cyc("lu_rt_used");
    IDEX_MemRead = 1'b0;
    cyc("lu_not_load");

    // Control hazards
    clear_inputs();
    ID_BranchTaken = 1'b1;
    cyc("branch");
    clear_inputs();
    ID_Jump = 1'b1;
    cyc("jump");
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; ID_Rs = 5'd9;
    cyc("jump_lu");
    clear_inputs();

    // Mul/div stall with HI/LO read held throughout
    do_reset();
    ID_ReadsHiLo = 1'b1;
    EX_MulDivStart = 1'b1;
    cyc("md_T");
    EX_MulDivStart = 1'b0;
    for (int i = 1; i <= 5; i++) cyc($sformatf("md_T+%0d", i));
    chk("md_count", int'(sc16), 3);
    clear_inputs();

    // Reset in the middle of a mul/div
    do_reset();
    EX_MulDivStart = 1'b1;
    cyc("mdr_T");
    EX_MulDivStart = 1'b0;
    ID_ReadsHiLo = 1'b1;
    cyc("mdr_T+1");
    RESET = 1'b1;
    cyc("mdr_reset");
    RESET = 1'b0;
    cyc("mdr_after");
    cyc("mdr_after2");
    clear_inputs();

    // Back-to-back mul/div, then a forced restart while busy
    do_reset();
    EX_MulDivStart = 1'b1;
    cyc("b2b_T");
    EX_MulDivStart = 1'b0;
    ID_IsMulDiv = 1'b1;
    for (int i = 1; i <= 4; i++) cyc($sformatf("b2b_hold%0d", i));
    ID_IsMulDiv = 1'b0;
    EX_MulDivStart = 1'b1;
    cyc("b2b_issue");
    EX_MulDivStart = 1'b0;
    cyc("b2b_busy1");
    EX_MulDivStart = 1'b1;
    cyc("b2b_restart");
    EX_MulDivStart = 1'b0;
    for (int i = 1; i <= 5; i++) cyc($sformatf("b2b_post%0d", i));
    chk("b2b_count", int'(sc16), 3);

    // Saturation of the 4-bit counter
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; ID_Rs = 5'd5;
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i));
    chk("sat_final4", int'(sc4), 15);
    chk("sat_final16", int'(sc16), 20);
    clear_inputs();

    // Randomized mix
    do_reset();
    for (int i = 0; i < 80; i++) begin
      RESET          = ($urandom_range(0, 24) == 0);
      ID_Rs          = 5'($urandom_range(0, 3));
      ID_Rt          = 5'($urandom_range(0, 3));
      IDEX_Rt        = 5'($urandom_range(0, 3));
      ID_UsesRt      = 1'($urandom_range(0, 1));
      ID_IsMulDiv    = ($urandom_range(0, 3) == 0);
      ID_ReadsHiLo   = ($urandom_range(0, 3) == 0);
      ID_BranchTaken = ($urandom_range(0, 3) == 0);
      ID_Jump        = ($urandom_range(0, 5) == 0);
      IDEX_MemRead   = ($urandom_range(0, 2) == 0);
      EX_MulDivStart = ($urandom_range(0, 5) == 0);
      cyc($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
